// File: rtl/kbdmk1_kbdside.sv
// MK-I keyboard link, keyboard (responder) side.
// Receives the LED stream on kb_do and returns the key matrix on kb_di.
module kbdmk1_kbdside #(
    parameter int IDLE_CYCLES = 1000,
    parameter int FRAME_BITS  = 128,
    parameter int LED_BITS    = 96,
    parameter int KEY_BITS    = 80
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                kb_ck,
    input  logic                kb_do,
    output logic                kb_di,
    input  logic [0:KEY_BITS-1] key_matrix,
    output logic [0:23]         led1_rgb,
    output logic [0:23]         led2_rgb,
    output logic [0:23]         led3_rgb,
    output logic [0:23]         led4_rgb,
    output logic                led_valid,
    output logic                frame_error
);

    localparam int IW = $clog2(FRAME_BITS + 1);
    localparam int CW = $clog2(IDLE_CYCLES + 1);

    localparam logic [IW-1:0] LED_N  = IW'(LED_BITS);
    localparam logic [IW-1:0] KEY_N  = IW'(KEY_BITS);
    localparam logic [IW-1:0] LAST_N = IW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] IDLE_N = CW'(IDLE_CYCLES);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic                ck_m;
    logic                ck_s;
    logic                ck_p;
    logic                do_m;
    logic                do_s;
    logic                rise;
    logic                fall;
    logic                idle;
    logic [CW-1:0]       idle_cnt;
    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [0:KEY_BITS-1] ret;
    logic [0:LED_BITS-1] shadow;

    assign rise = ck_s & ~ck_p;
    assign fall = ~ck_s & ck_p;
    assign idle = (idle_cnt == IDLE_N);

    // Two-flop synchronizers plus the previous-sample flop for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ck_m <= 1'b1;
            ck_s <= 1'b1;
            ck_p <= 1'b1;
            do_m <= 1'b1;
            do_s <= 1'b1;
        end else begin
            ck_m <= kb_ck;
            ck_s <= ck_m;
            ck_p <= ck_s;
            do_m <= kb_do;
            do_s <= do_m;
        end
    end

    // Counts how long kb_ck has been quietly high; saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (rise || fall || !ck_s) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_N) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Frame sequencer: arm on idle, shift bits on edges, publish on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_WAIT;
            idx         <= '0;
            kb_di       <= 1'b1;
            ret         <= '0;
            shadow      <= '0;
            led1_rgb    <= '0;
            led2_rgb    <= '0;
            led3_rgb    <= '0;
            led4_rgb    <= '0;
            led_valid   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            led_valid   <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                S_WAIT: begin
                    kb_di <= 1'b1;
                    if (idle) begin
                        ret   <= {key_matrix[1:KEY_BITS-1], 1'b0};
                        kb_di <= ~key_matrix[0];
                        idx   <= '0;
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (rise) begin
                        shadow <= {shadow[1:LED_BITS-1], do_s};
                        idx    <= {{(IW-1){1'b0}}, 1'b1};
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (idle && idx != '0) begin
                        // The gap that aborted this frame starts the next one.
                        frame_error <= 1'b1;
                        ret         <= {key_matrix[1:KEY_BITS-1], 1'b0};
                        kb_di       <= ~key_matrix[0];
                        idx         <= '0;
                        state       <= S_ARMED;
                    end else if (fall) begin
                        if (idx < KEY_N) begin
                            kb_di <= ~ret[0];
                            ret   <= {ret[1:KEY_BITS-1], 1'b0};
                        end else begin
                            kb_di <= 1'b1;
                        end
                    end else if (rise) begin
                        if (idx < LED_N) begin
                            shadow <= {shadow[1:LED_BITS-1], do_s};
                        end
                        idx <= idx + 1'b1;
                        if (idx == LAST_N) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    led1_rgb  <= shadow[0:23];
                    led2_rgb  <= shadow[24:47];
                    led3_rgb  <= shadow[48:71];
                    led4_rgb  <= shadow[72:95];
                    led_valid <= 1'b1;
                    kb_di     <= 1'b1;
                    state     <= S_WAIT;
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule
